// File: rtl/id_hazard_ctrl.sv
// Decode-stage register scoreboard: tracks pending long-latency writes, stalls on
// RAW/WAW/capacity hazards, counts stall cycles and flags stalls that never clear.
module id_hazard_ctrl #(
   parameter int unsigned REG_NUM         = 32,
   parameter int unsigned RADDR_WIDTH     = 5,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          BYPASS          = 1'b1,
   parameter int unsigned CNT_WIDTH       = 32,
   parameter int unsigned TIMEOUT         = 255,
   localparam int unsigned OUT_WIDTH      = $clog2(MAX_OUTSTANDING) + 1,
   localparam int unsigned WD_WIDTH       = $clog2(TIMEOUT + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid_i,
   input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
   input  logic                   reg1_re_i,
   input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
   input  logic                   reg2_re_i,
   input  logic                   reg_we_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   long_i,
   input  logic                   flush_i,
   input  logic                   wb_we_i,
   input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
   output logic                   stall_o,
   output logic                   issue_o,
   output logic [REG_NUM-1:0]     busy_o,
   output logic [OUT_WIDTH-1:0]   outstanding_o,
   output logic [CNT_WIDTH-1:0]   stall_cnt_o,
   output logic                   hazard_err_o
);

   typedef enum logic {StRun, StStalled} wd_state_e;

   logic [REG_NUM-1:0]   busy_q, busy_d;
   logic [REG_NUM-1:0]   wb_onehot, ebusy;
   logic [OUT_WIDTH-1:0] outstanding_q, outstanding_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [WD_WIDTH-1:0]  wd_cnt_q;
   wd_state_e            wd_state_q;
   logic                 hazard_err_q;
   logic                 wb_clr, set_en, full, hazard, active;

   always_comb begin
      wb_onehot = '0;
      if (wb_we_i) wb_onehot[wb_waddr_i] = 1'b1;
   end

   // With write-through, the register being written back this cycle is already readable.
   assign ebusy  = BYPASS ? (busy_q & ~wb_onehot) : busy_q;
   assign wb_clr = wb_we_i & busy_q[wb_waddr_i];
   assign full   = (outstanding_q == OUT_WIDTH'(MAX_OUTSTANDING));

   assign hazard = (reg1_re_i & ebusy[reg1_raddr_i])
                 | (reg2_re_i & ebusy[reg2_raddr_i])
                 | (reg_we_i & ebusy[reg_waddr_i])
                 | (reg_we_i & long_i & (reg_waddr_i != '0) & full & ~wb_clr);

   assign active  = id_valid_i & ~flush_i;
   assign stall_o = active & hazard;
   assign issue_o = active & ~hazard;
   assign set_en  = issue_o & reg_we_i & long_i & (reg_waddr_i != '0);

   // Clear before set so a same-register set/clear leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wb_clr) busy_d[wb_waddr_i] = 1'b0;
      if (set_en) busy_d[reg_waddr_i] = 1'b1;
   end

   always_comb begin
      outstanding_d = outstanding_q;
      unique case ({set_en, wb_clr})
         2'b10:   outstanding_d = outstanding_q + OUT_WIDTH'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_WIDTH'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= '0;
         outstanding_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         busy_q        <= busy_d;
         outstanding_q <= outstanding_d;
         if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Watchdog: counts consecutive stall cycles; the error is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_state_q   <= StRun;
         wd_cnt_q     <= '0;
         hazard_err_q <= 1'b0;
      end else begin
         unique case (wd_state_q)
            StRun: begin
               if (stall_o) begin
                  wd_state_q <= StStalled;
                  wd_cnt_q   <= WD_WIDTH'(1);
                  if (TIMEOUT <= 1) hazard_err_q <= 1'b1;
               end
            end
            StStalled: begin
               if (!stall_o) begin
                  wd_state_q <= StRun;
                  wd_cnt_q   <= '0;
               end else begin
                  if (wd_cnt_q != WD_WIDTH'(TIMEOUT)) wd_cnt_q <= wd_cnt_q + WD_WIDTH'(1);
                  if (wd_cnt_q >= WD_WIDTH'(TIMEOUT - 1)) hazard_err_q <= 1'b1;
               end
            end
            default: wd_state_q <= StRun;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign outstanding_o = outstanding_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign hazard_err_o  = hazard_err_q;

endmodule
